// File: rtl/fifo_ctrl_fsm_n_if.sv
// fifo_ctrl_fsm_n_if: control/status bundle between the FIFO bank controller and its environment
interface fifo_ctrl_fsm_n_if #(
    parameter int NUM_FIFOS = 5,
    parameter int UW = 4
);
    logic init;
    logic err_clear;
    logic [NUM_FIFOS*UW-1:0] umbral_in;
    logic [NUM_FIFOS*UW-1:0] umbral_out;
    logic [NUM_FIFOS-1:0] fifo_empty;
    logic [NUM_FIFOS-1:0] fifo_error;
    logic [NUM_FIFOS-1:0] error_src;
    logic [4:0] state;
    logic idle_out;
    logic active_out;
    logic error_out;
    logic umbral_valid;
    modport master (
        output init, err_clear, umbral_in, fifo_empty, fifo_error,
        input state, idle_out, active_out, error_out, error_src, umbral_out, umbral_valid
    );
    modport slave (
        input init, err_clear, umbral_in, fifo_empty, fifo_error,
        output state, idle_out, active_out, error_out, error_src, umbral_out, umbral_valid
    );
endinterface

// File: rtl/fifo_ctrl_fsm_n.sv
// fifo_ctrl_fsm_n: threshold programming, idle/active tracking with drain timeout and sticky error capture for a FIFO bank
module fifo_ctrl_fsm_n #(
    parameter int NUM_FIFOS = 5,
    parameter int UW = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    fifo_ctrl_fsm_n_if.slave bus
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;
    state_t st;
    logic [CW-1:0] cnt;
    logic [NUM_FIFOS-1:0] src;
    logic [NUM_FIFOS*UW-1:0] umb;
    logic valid;
    logic any_err;
    logic all_empty;
    logic drained;
    assign any_err = |bus.fifo_error;
    assign all_empty = &bus.fifo_empty;
    assign drained = cnt == CW'(DRAIN_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_RESET;
            cnt <= '0;
            src <= '0;
            umb <= '0;
            valid <= 1'b0;
        end else begin
            case (st)
                S_RESET: st <= S_INIT;
                S_INIT: begin
                    umb <= bus.umbral_in;
                    if (bus.init) begin
                        valid <= 1'b1;
                        st <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (any_err) begin
                        src <= bus.fifo_error;
                        st <= S_ERROR;
                    end else if (!all_empty) begin
                        cnt <= '0;
                        st <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (any_err) begin
                        src <= bus.fifo_error;
                        st <= S_ERROR;
                    end else if (!all_empty) begin
                        cnt <= '0;
                    end else if (drained) begin
                        cnt <= '0;
                        st <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ERROR: begin
                    // clear takes precedence over errors arriving in the same cycle
                    if (bus.err_clear) begin
                        src <= '0;
                        valid <= 1'b0;
                        st <= S_INIT;
                    end else begin
                        src <= src | bus.fifo_error;
                    end
                end
                default: begin
                    st <= S_RESET;
                    cnt <= '0;
                    src <= '0;
                    umb <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end
    assign bus.state = st;
    assign bus.idle_out = st[2];
    assign bus.active_out = st[3];
    assign bus.error_out = st[4];
    assign bus.error_src = src;
    assign bus.umbral_out = umb;
    assign bus.umbral_valid = valid;
endmodule

// File: tb/tb_fifo_ctrl_fsm_n.sv
// tb_fifo_ctrl_fsm_n: vector table, corner sequences and randomized model comparison for fifo_ctrl_fsm_n
module tb_fifo_ctrl_fsm_n;
    localparam int N = 5;
    localparam int UW = 4;
    localparam int D = 4;
    localparam int W = N * UW;
    localparam int NB = 8;
    localparam int WB = NB * UW;
    localparam logic [4:0] SR = 5'b00001;
    localparam logic [4:0] SI = 5'b00010;
    localparam logic [4:0] SD = 5'b00100;
    localparam logic [4:0] SA = 5'b01000;
    localparam logic [4:0] SE = 5'b10000;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    fifo_ctrl_fsm_n_if #(.NUM_FIFOS(N), .UW(UW)) ia ();
    fifo_ctrl_fsm_n_if #(.NUM_FIFOS(NB), .UW(UW)) ib ();
    fifo_ctrl_fsm_n #(.NUM_FIFOS(N), .UW(UW), .DRAIN_CYCLES(D)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    fifo_ctrl_fsm_n #(.NUM_FIFOS(NB), .UW(UW), .DRAIN_CYCLES(1)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst, ini, clr;
        logic [W-1:0] ui;
        logic [N-1:0] emp, err;
        logic [4:0] st;
        logic [N-1:0] src;
        logic [W-1:0] uo;
        logic v;
    } vec_t;
    vec_t vecs[$];

    typedef enum int {M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4} mstate_t;
    mstate_t mm;
    int run;
    logic [N-1:0] msrc;
    logic [W-1:0] mumb;
    logic mv;

    function automatic vec_t mk(logic r, logic i, logic c, logic [W-1:0] ui, logic [N-1:0] emp,
                                logic [N-1:0] err, logic [4:0] st, logic [N-1:0] src, logic [W-1:0] uo, logic v);
        vec_t x;
        x.rst = r; x.ini = i; x.clr = c; x.ui = ui; x.emp = emp; x.err = err;
        x.st = st; x.src = src; x.uo = uo; x.v = v;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(logic r, logic i, logic c, logic [W-1:0] ui, logic [N-1:0] emp, logic [N-1:0] err);
        rst_a = r;
        ia.init = i;
        ia.err_clear = c;
        ia.umbral_in = ui;
        ia.fifo_empty = emp;
        ia.fifo_error = err;
    endtask

    task automatic check_a(string name, logic [4:0] st, logic [N-1:0] src, logic [W-1:0] uo, logic v);
        logic [8+N+W:0] got, exp;
        got = {ia.state, ia.idle_out, ia.active_out, ia.error_out, ia.error_src, ia.umbral_out, ia.umbral_valid};
        exp = {st, st == SD, st == SA, st == SE, src, uo, v};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st=%b flags=%b%b%b src=%h umb=%h v=%b, exp st=%b flags=%b%b%b src=%h umb=%h v=%b",
                     name, ia.state, ia.idle_out, ia.active_out, ia.error_out, ia.error_src, ia.umbral_out,
                     ia.umbral_valid, st, st == SD, st == SA, st == SE, src, uo, v);
        end
    endtask

    task automatic check_b(string name, logic [4:0] st, logic [NB-1:0] src, logic [WB-1:0] uo, logic v);
        logic [8+NB+WB:0] got, exp;
        got = {ib.state, ib.idle_out, ib.active_out, ib.error_out, ib.error_src, ib.umbral_out, ib.umbral_valid};
        exp = {st, st == SD, st == SA, st == SE, src, uo, v};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    // reference: counts consecutive all-empty cycles and leaves ACTIVE once that run equals D
    task automatic model_step(logic r, logic i, logic c, logic [W-1:0] ui, logic [N-1:0] emp, logic [N-1:0] err);
        if (r) begin
            mm = M_RST; run = 0; msrc = '0; mumb = '0; mv = 1'b0;
        end else if (mm == M_RST) begin
            mm = M_INIT;
        end else if (mm == M_INIT) begin
            mumb = ui;
            if (i) begin mv = 1'b1; mm = M_IDLE; end
        end else if (mm == M_ERR) begin
            if (c) begin msrc = '0; mv = 1'b0; mm = M_INIT; end
            else msrc = msrc | err;
        end else if (err != '0) begin
            msrc = err; mm = M_ERR;
        end else if (mm == M_IDLE) begin
            if (emp != {N{1'b1}}) begin run = 0; mm = M_ACT; end
        end else begin
            if (emp != {N{1'b1}}) run = 0;
            else begin
                run++;
                if (run == D) begin run = 0; mm = M_IDLE; end
            end
        end
    endtask

    initial begin
        rst_b = 1'b1;
        ib.init = 1'b0; ib.err_clear = 1'b0; ib.umbral_in = '0; ib.fifo_empty = '1; ib.fifo_error = '0;
        drive_a(1, 0, 0, '0, '1, '0);

        vecs.push_back(mk(1,0,0,'h12345,'h1f,0, SR,0,0,0));
        vecs.push_back(mk(1,0,0,'h12345,'h1f,0, SR,0,0,0));
        vecs.push_back(mk(0,0,0,'h12345,'h1f,0, SI,0,0,0));
        vecs.push_back(mk(0,0,0,'h12345,'h1f,0, SI,0,'h12345,0));
        vecs.push_back(mk(0,0,0,'h12345,'h1f,0, SI,0,'h12345,0));
        vecs.push_back(mk(0,1,0,'hABCDE,'h1f,0, SD,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SD,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1e,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SD,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1e,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1e,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SA,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1f,0, SD,0,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1e,'h04, SE,'h04,'hABCDE,1));
        vecs.push_back(mk(0,0,0,'h00000,'h1e,'h01, SE,'h05,'hABCDE,1));
        vecs.push_back(mk(0,0,1,'h00000,'h1f,'h10, SI,0,'hABCDE,0));
        vecs.push_back(mk(0,0,0,'h11111,'h1f,0, SI,0,'h11111,0));
        vecs.push_back(mk(0,1,0,'h22222,'h1f,0, SD,0,'h22222,1));
        vecs.push_back(mk(0,0,0,'h22222,'h1e,0, SA,0,'h22222,1));
        vecs.push_back(mk(0,0,0,'h22222,'h1f,0, SA,0,'h22222,1));
        vecs.push_back(mk(0,0,0,'h22222,'h1f,0, SA,0,'h22222,1));
        vecs.push_back(mk(1,0,0,'h22222,'h1f,0, SR,0,0,0));
        vecs.push_back(mk(0,0,0,'h22222,'h1f,0, SI,0,0,0));
        vecs.push_back(mk(0,0,1,'h33333,'h1e,'h1f, SI,0,'h33333,0));
        vecs.push_back(mk(0,1,0,'h44444,'h1f,0, SD,0,'h44444,1));
        vecs.push_back(mk(0,1,0,'h55555,'h1f,0, SD,0,'h44444,1));
        vecs.push_back(mk(0,0,1,'h55555,'h1f,0, SD,0,'h44444,1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].rst, vecs[i].ini, vecs[i].clr, vecs[i].ui, vecs[i].emp, vecs[i].err);
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].st, vecs[i].src, vecs[i].uo, vecs[i].v);
        end

        // single all-empty cycle drains when DRAIN_CYCLES is 1
        tick();
        check_b("b_reset", SR, '0, '0, 1'b0);
        rst_b = 1'b0;
        tick();
        check_b("b_init", SI, '0, '0, 1'b0);
        ib.init = 1'b1; ib.umbral_in = 32'hCAFE1234;
        tick();
        check_b("b_idle", SD, '0, 32'hCAFE1234, 1'b1);
        ib.init = 1'b0; ib.fifo_empty = 8'hFE;
        tick();
        check_b("b_active", SA, '0, 32'hCAFE1234, 1'b1);
        ib.fifo_empty = 8'hFF;
        tick();
        check_b("b_drain1", SD, '0, 32'hCAFE1234, 1'b1);
        ib.fifo_error = 8'h80;
        tick();
        check_b("b_err", SE, 8'h80, 32'hCAFE1234, 1'b1);
        ib.fifo_error = 8'h00;
        tick();
        check_b("b_sticky", SE, 8'h80, 32'hCAFE1234, 1'b1);
        ib.err_clear = 1'b1;
        tick();
        check_b("b_clear", SI, '0, 32'hCAFE1234, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic r, ini, clr;
            logic [W-1:0] ui;
            logic [N-1:0] emp, err;
            r = (i == 0) || ($urandom_range(63) == 0);
            ini = $urandom_range(3) == 0;
            clr = $urandom_range(3) == 0;
            ui = W'($urandom);
            emp = $urandom_range(1) == 1 ? {N{1'b1}} : N'($urandom);
            err = $urandom_range(15) == 0 ? N'($urandom) : '0;
            drive_a(r, ini, clr, ui, emp, err);
            model_step(r, ini, clr, ui, emp, err);
            tick();
            check_a($sformatf("rand%0d", i), 5'(1 << int'(mm)), msrc, mumb, mv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl_fsm_n.md
Name: fifo_ctrl_fsm_n

Overview:
Parametrised power/flow-control state machine for the transmit-side FIFO bank: main FIFO, VC FIFOs and D FIFOs, generalised to NUM_FIFOS channels.
- Programs and freezes per-FIFO thresholds (umbrales) during INIT.
- Tracks IDLE/ACTIVE from the FIFO empty flags, with a drain timeout back to IDLE.
- Latches a sticky per-FIFO error source.
- Supports software error recovery without a full reset.
- Sits beside the FIFO bank; its threshold outputs feed the FIFOs' almost-full/almost-empty logic.

Parameters:
NUM_FIFOS, 5, number of FIFOs monitored; bit i of every vector refers to FIFO i.
UW, 4, width of each threshold field.
DRAIN_CYCLES, 4, consecutive all-empty cycles in ACTIVE before returning to IDLE; legal range >= 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
init  in  1  ends threshold programming; sampled only in INIT.
umbral_in  in  NUM_FIFOS*UW  threshold for FIFO i in bits [i*UW +: UW].
fifo_empty  in  NUM_FIFOS  empty flag per FIFO.
fifo_error  in  NUM_FIFOS  overflow/underflow error pulse or level per FIFO.
err_clear  in  1  leaves ERROR; sampled only in ERROR.
state  out  5  one-hot present state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
idle_out  out  1  high while state==IDLE.
active_out  out  1  high while state==ACTIVE.
error_out  out  1  high while state==ERROR.
error_src  out  NUM_FIFOS  sticky OR of fifo_error bits seen in ERROR.
umbral_out  out  NUM_FIFOS*UW  programmed thresholds.
umbral_valid  out  1  high when thresholds are frozen (IDLE/ACTIVE/ERROR).

Behaviour:
- All outputs are registered. A condition sampled at edge N is visible after edge N. Flags are registered together with state, so flags always agree with state.
- Reset: when reset=1 at an edge, state=RESET and every other output is 0, including umbral_out, error_src and the drain counter. This applies in any state and mid-operation, and has priority over every transition below.
- RESET: unconditionally go to INIT on the next edge with reset=0.
- INIT:
  - Each cycle, umbral_out <= umbral_in (tracking).
  - If init=1, umbral_out <= umbral_in (the final capture uses that cycle's value), umbral_valid <= 1, go to IDLE.
  - fifo_empty and fifo_error are ignored in INIT.
- Thresholds are held constant outside INIT; umbral_in changes are ignored.
- IDLE:
  - Priority 1: |fifo_error -> ERROR, error_src <= fifo_error.
  - Priority 2: any fifo_empty bit 0 -> ACTIVE, drain counter <= 0.
  - Otherwise stay in IDLE.
- ACTIVE:
  - Priority 1: |fifo_error -> ERROR, error_src <= fifo_error.
  - If fifo_empty == all ones: increment the drain counter. When the counter reaches DRAIN_CYCLES-1 and fifo_empty is still all ones, go to IDLE on that edge. The transition occurs on the DRAIN_CYCLES-th consecutive all-empty cycle.
  - Any non-empty cycle resets the drain counter to 0.
  - Counter width is clog2(DRAIN_CYCLES+1); it never wraps.
- ERROR:
  - error_src <= error_src | fifo_error every cycle (sticky accumulation).
  - If err_clear=1: error_src <= 0, umbral_valid <= 0, go to INIT. err_clear wins over a simultaneous new fifo_error.
  - umbral_out is retained through recovery and re-tracks in INIT.
- init outside INIT and err_clear outside ERROR have no effect.
- Illegal or unreachable state encodings go to RESET on the next edge, with outputs as after reset.

Test Plan:
1. Reset and program, NUM_FIFOS=5, UW=4, DRAIN_CYCLES=4.
   - Stimulus: reset 2 cycles; umbral_in=0x12345 with init=0 for 3 cycles, then init=1 with umbral_in=0xABCDE.
   - Required: state RESET -> INIT -> IDLE; umbral_out=0xABCDE; umbral_valid=1 after the init edge.
   - Required: a later change to umbral_in=0 leaves umbral_out=0xABCDE.
2. Activity and drain.
   - Stimulus: in IDLE, fifo_empty=11110 for 1 cycle.
   - Required: ACTIVE next cycle; active_out=1, idle_out=0.
   - Stimulus: then fifo_empty=11111.
   - Required: IDLE exactly after the 4th all-empty edge.
   - Stimulus: all-empty for 3 cycles, 1 non-empty, then 3 all-empty.
   - Required: stays ACTIVE.
3. Error priority and sticky source.
   - Stimulus: in IDLE, fifo_error=00100 with fifo_empty=11110 in the same cycle.
   - Required: ERROR, not ACTIVE; error_src=00100.
   - Stimulus: next fifo_error=00001.
   - Required: error_src=00101; error_out=1, active_out=0.
4. Recovery.
   - Stimulus: in ERROR, err_clear=1 with fifo_error=10000 in the same cycle.
   - Required: INIT next cycle; error_src=0, umbral_valid=0, error_out=0; umbral_out holds its old value until the next INIT cycle re-tracks.
5. Reset mid-operation.
   - Stimulus: reset=1 for 1 cycle while in ACTIVE with drain counter=2.
   - Required: state=00001 and all outputs 0.
   - Stimulus: after reset deasserts with fifo_empty=11111.
   - Required: no return to ACTIVE; INIT is entered.
6. Parameter sweep with NUM_FIFOS=8, DRAIN_CYCLES=1.
   - Stimulus: a single all-empty cycle in ACTIVE.
   - Required: IDLE.
   - Stimulus: fifo_error=10000000.
   - Required: error_src=10000000.
